// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data_memory instance between the RV32I core load/store port
// (port 0) and a secondary bus master (port 1). One requester is granted per
// cycle. Each grant is a single-cycle memory transaction. Read data is
// registered back to the requester one cycle after the grant.
//
// Arbitration order:
//   1. locked owner only
//   2. port 1 once it has starved for STARVE_LIMIT cycles (optional)
//   3. port 0
//   4. port 1
//
// Optional feature macro: DMEM_ARB_STARVE_GUARD_EN
//   defined   -> starvation counter and port-1 override are present
//   undefined -> strict port-0 priority, STARVE_LIMIT has no effect
//
// Parameters:
//   STARVE_LIMIT  port-1 waiting cycles before it overrides port 0 (1..255)
//   MAX_LOCK      max consecutive granted cycles of a locked owner (1..255)
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   pN_req/we/lock/func3/addr/wdata  request payload of port N (N = 0, 1)
//   pN_gnt                           combinational grant
//   pN_rvalid, pN_rdata              registered read return
//   core_stall                       port 0 requesting but not granted
//   MemRead, MemWrite, mem_func3,
//   mem_addr, mem_w_data             memory request from the winner
//   mem_r_data                       combinational memory read data
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned MAX_LOCK     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_lock,
  input  logic [2:0]  p0_func3,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [2:0]  p1_func3,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        core_stall,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
  end
  if (MAX_LOCK < 1 || MAX_LOCK > 255) begin : g_bad_max_lock
    $error("dmem_arbiter: MAX_LOCK must be in 1..255");
  end

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t      state, state_next;
  logic        owner, owner_next;        // 0 = port 0, 1 = port 1
  logic [7:0]  lock_cnt, lock_cnt_next;
  logic        owner_req, owner_lock;
  logic        starve_hit;

  assign owner_req  = owner ? p1_req  : p0_req;
  assign owner_lock = owner ? p1_lock : p0_lock;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;

  assign starve_hit = (starve_cnt == 8'(STARVE_LIMIT));

  // Counts cycles port 1 waits; saturates at the limit, holds while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (p1_gnt) begin
      starve_cnt <= '0;
    end else if (p1_req && !starve_hit) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Grant decision. Reset forces all grants low even with requests pending.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (state == ST_LOCKED) begin
        p0_gnt = ~owner & p0_req;
        p1_gnt =  owner & p1_req;
      end else if (starve_hit && p1_req) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  assign core_stall = p0_req & ~p0_gnt;

  // Lock FSM next state. A lock grant that already hits MAX_LOCK (MAX_LOCK=1)
  // never enters LOCKED, so the port gets exactly that one cycle.
  always_comb begin
    state_next    = state;
    owner_next    = owner;
    lock_cnt_next = lock_cnt;
    case (state)
      ST_OPEN: begin
        if ((p0_gnt && p0_lock) || (p1_gnt && p1_lock)) begin
          lock_cnt_next = 8'd1;
          if (8'(MAX_LOCK) != 8'd1) begin
            state_next = ST_LOCKED;
            owner_next = p1_gnt;
          end
        end
      end
      ST_LOCKED: begin
        // While locked, an owner request is always an owner grant.
        if (owner_req) begin
          lock_cnt_next = lock_cnt + 8'd1;
        end
        if (!owner_req || !owner_lock || (lock_cnt + 8'd1 == 8'(MAX_LOCK))) begin
          state_next = ST_OPEN;
        end
      end
      default: state_next = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OPEN;
      owner    <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  // Memory request mux; everything is zero when nobody is granted.
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    mem_func3  = '0;
    mem_addr   = '0;
    mem_w_data = '0;
    if (p0_gnt) begin
      MemRead    = ~p0_we;
      MemWrite   =  p0_we;
      mem_func3  = p0_func3;
      mem_addr   = p0_addr;
      mem_w_data = p0_wdata;
    end else if (p1_gnt) begin
      MemRead    = ~p1_we;
      MemWrite   =  p1_we;
      mem_func3  = p1_func3;
      mem_addr   = p1_addr;
      mem_w_data = p1_wdata;
    end
  end

  // Read return: capture at the edge ending the read grant; rdata holds
  // until the next read of the same port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= p0_gnt & ~p0_we;
      p1_rvalid <= p1_gnt & ~p1_we;
      if (p0_gnt && !p0_we) begin
        p0_rdata <= mem_r_data;
      end
      if (p1_gnt && !p1_we) begin
        p1_rdata <= mem_r_data;
      end
    end
  end

endmodule
